// File: rtl/wb_stage_unit.sv
// Write-back stage: M/W pipeline register, GRF write decode, in-stage load
// extension and a retired-instruction counter.
module wb_stage_unit #(
   parameter int DATA_W   = 32,
   parameter int RA_W     = 5,
   parameter int LINK_REG = 31,
   parameter int LINK_OFF = 8,
   parameter int LANE_W   = $clog2(DATA_W/8)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              m_valid,
   input  logic [31:0]       m_ir,
   input  logic [31:0]       m_pc,
   input  logic [DATA_W-1:0] m_alu,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic [LANE_W-1:0] m_addr_lo,
   input  logic [DATA_W-1:0] m_cp0,
   input  logic              stall,
   input  logic              flush,
   output logic              w_valid,
   output logic              w_we,
   output logic [RA_W-1:0]   w_waddr,
   output logic [DATA_W-1:0] w_wdata,
   output logic [31:0]       w_pc,
   output logic [31:0]       instret
);

   typedef struct packed {
      logic              valid;
      logic [31:0]       ir;
      logic [31:0]       pc;
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] rdata;
      logic [LANE_W-1:0] addr_lo;
      logic [DATA_W-1:0] cp0;
   } w_reg_t;

   w_reg_t      w_q;
   logic [31:0] instret_q;
   logic [31:0] instret_cur;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         w_q <= '0;
      end else if (flush) begin
         w_q.valid <= 1'b0;
         w_q.ir    <= '0;
      end else if (!stall) begin
         w_q.valid   <= m_valid;
         w_q.ir      <= m_ir;
         w_q.pc      <= m_pc;
         w_q.alu     <= m_alu;
         w_q.rdata   <= m_rdata;
         w_q.addr_lo <= m_addr_lo;
         w_q.cp0     <= m_cp0;
      end
   end

   // The instruction leaving W retires even if W is being flushed behind it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         instret_q <= '0;
      else if (w_q.valid && !stall)
         instret_q <= instret_cur + 32'd1;
   end

   assign instret_cur = instret_q;

   logic [5:0] op, funct;
   logic [4:0] rs, rt, rd;

   assign op    = w_q.ir[31:26];
   assign rs    = w_q.ir[25:21];
   assign rt    = w_q.ir[20:16];
   assign rd    = w_q.ir[15:11];
   assign funct = w_q.ir[5:0];

   logic unused_shamt;
   assign unused_shamt = ^w_q.ir[10:6];

   // Little-endian lane select; misaligned low address bits are dropped.
   logic [LANE_W-1:0] half_lane, word_lane;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [31:0]       ld_word;

   assign half_lane = w_q.addr_lo & ~LANE_W'(1);
   assign word_lane = w_q.addr_lo & ~LANE_W'(3);
   assign ld_byte   = w_q.rdata[{w_q.addr_lo, 3'b000} +: 8];
   assign ld_half   = w_q.rdata[{half_lane, 3'b000} +: 16];
   assign ld_word   = w_q.rdata[{word_lane, 3'b000} +: 32];

   logic [DATA_W-1:0] ld_val;

   always_comb begin
      ld_val = '0;
      case (op)
         6'h20:   ld_val = DATA_W'($signed(ld_byte));
         6'h21:   ld_val = DATA_W'($signed(ld_half));
         6'h23:   ld_val = DATA_W'($signed(ld_word));
         6'h24:   ld_val = DATA_W'(ld_byte);
         6'h25:   ld_val = DATA_W'(ld_half);
         default: ld_val = '0;
      endcase
   end

   logic [DATA_W-1:0] link_val;
   assign link_val = DATA_W'(w_q.pc + 32'(LINK_OFF));

   logic rr_funct;

   always_comb begin
      rr_funct = 1'b0;
      case (funct)
         6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
         6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
         6'h26, 6'h27, 6'h2A, 6'h2B: rr_funct = 1'b1;
         default:                    rr_funct = 1'b0;
      endcase
   end

   logic              cls_hit;
   logic [RA_W-1:0]   waddr_d;
   logic [DATA_W-1:0] wdata_d;

   always_comb begin
      cls_hit = 1'b0;
      waddr_d = '0;
      wdata_d = '0;
      if (op == 6'h00 && rr_funct) begin
         cls_hit = 1'b1;
         waddr_d = RA_W'(rd);
         wdata_d = w_q.alu;
      end else if (op == 6'h00 && funct == 6'h09) begin
         cls_hit = 1'b1;
         waddr_d = RA_W'(rd);
         wdata_d = link_val;
      end else if (op[5:3] == 3'b001) begin
         cls_hit = 1'b1;
         waddr_d = RA_W'(rt);
         wdata_d = w_q.alu;
      end else if (op == 6'h20 || op == 6'h21 || op == 6'h23 ||
                   op == 6'h24 || op == 6'h25) begin
         cls_hit = 1'b1;
         waddr_d = RA_W'(rt);
         wdata_d = ld_val;
      end else if (op == 6'h10 && rs == 5'd0) begin
         cls_hit = 1'b1;
         waddr_d = RA_W'(rt);
         wdata_d = w_q.cp0;
      end else if (op == 6'h03) begin
         cls_hit = 1'b1;
         waddr_d = RA_W'(LINK_REG);
         wdata_d = link_val;
      end
   end

   // $0 is hardwired; suppressing here also keeps sll-nops off the hazard unit.
   assign w_we    = w_q.valid & cls_hit & (waddr_d != '0);
   assign w_waddr = waddr_d;
   assign w_wdata = wdata_d;
   assign w_valid = w_q.valid;
   assign w_pc    = w_q.pc;
   assign instret = instret_cur;

endmodule

// File: tb/tb_wb_stage_unit.sv
// Bench for wb_stage_unit: vector table through a scoreboard queue, plus
// stall/flush/bubble, counter wrap and asynchronous reset sequences.
module tb_wb_stage_unit;
   localparam int DW = 32;
   localparam int RW = 5;
   localparam int LW = 2;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic          m_valid = 1'b0;
   logic [31:0]   m_ir = '0;
   logic [31:0]   m_pc = '0;
   logic [DW-1:0] m_alu = '0;
   logic [DW-1:0] m_rdata = '0;
   logic [LW-1:0] m_addr_lo = '0;
   logic [DW-1:0] m_cp0 = '0;
   logic          stall = 1'b0;
   logic          flush = 1'b0;
   logic          w_valid, w_we;
   logic [RW-1:0] w_waddr;
   logic [DW-1:0] w_wdata;
   logic [31:0]   w_pc, instret;

   wb_stage_unit dut (
      .clk(clk), .reset_n(reset_n), .m_valid(m_valid), .m_ir(m_ir), .m_pc(m_pc),
      .m_alu(m_alu), .m_rdata(m_rdata), .m_addr_lo(m_addr_lo), .m_cp0(m_cp0),
      .stall(stall), .flush(flush), .w_valid(w_valid), .w_we(w_we),
      .w_waddr(w_waddr), .w_wdata(w_wdata), .w_pc(w_pc), .instret(instret)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]   ir;
      logic [31:0]   pc;
      logic [DW-1:0] alu;
      logic [DW-1:0] rdata;
      logic [LW-1:0] lo;
      logic [DW-1:0] cp0;
      logic          we;
      logic [RW-1:0] wa;
      logic [DW-1:0] wd;
   } vec_t;

   typedef struct {
      logic          valid;
      logic          we;
      logic [RW-1:0] wa;
      logic [DW-1:0] wd;
      logic [31:0]   pc;
   } exp_t;

   exp_t        sbq[$];
   vec_t        tbl[19];
   int          n_run = 0;
   int          n_fail = 0;
   logic        mdl_valid = 1'b0;
   logic [31:0] mdl_instret = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v, input logic vld);
      m_valid   = vld;
      m_ir      = v.ir;
      m_pc      = v.pc;
      m_alu     = v.alu;
      m_rdata   = v.rdata;
      m_addr_lo = v.lo;
      m_cp0     = v.cp0;
   endtask

   task automatic push_exp(input vec_t v);
      exp_t e;
      e.valid = 1'b1; e.we = v.we; e.wa = v.wa; e.wd = v.wd; e.pc = v.pc;
      sbq.push_back(e);
   endtask

   task automatic edge_step();
      @(posedge clk);
      if (mdl_valid && !stall) mdl_instret = mdl_instret + 32'd1;
      if (flush) mdl_valid = 1'b0;
      else if (!stall) mdl_valid = m_valid;
      #1;
   endtask

   task automatic check_out(input string nm);
      exp_t e;
      if (sbq.size() == 0) begin
         n_run++; n_fail++;
         $display("FAIL %s: scoreboard empty, got we=%0b", nm, w_we);
      end else begin
         e = sbq.pop_front();
         chk({nm, ".valid"}, 64'(w_valid), 64'(e.valid));
         chk({nm, ".we"},    64'(w_we),    64'(e.we));
         chk({nm, ".waddr"}, 64'(w_waddr), 64'(e.wa));
         chk({nm, ".wdata"}, 64'(w_wdata), 64'(e.wd));
         chk({nm, ".pc"},    64'(w_pc),    64'(e.pc));
      end
      chk({nm, ".instret"}, 64'(instret), 64'(mdl_instret));
   endtask

   function automatic vec_t mk(input logic [31:0] ir, input logic [31:0] pc,
                               input logic [DW-1:0] alu, input logic [DW-1:0] rdata,
                               input logic [LW-1:0] lo, input logic [DW-1:0] cp0,
                               input logic we, input logic [RW-1:0] wa,
                               input logic [DW-1:0] wd);
      vec_t v;
      v.ir = ir; v.pc = pc; v.alu = alu; v.rdata = rdata; v.lo = lo; v.cp0 = cp0;
      v.we = we; v.wa = wa; v.wd = wd;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t ori_v, mfc_v, lw_v;
      logic [31:0] rd_w;
      rd_w = 32'h80FF7F01;
      tbl[0]  = mk(32'h34081234, 32'h1000, 32'h1234,     '0,   2'd0, '0,        1'b1, 5'd8,  32'h1234);
      tbl[1]  = mk(32'h0C000C00, 32'h3000, 32'hDEAD,     '0,   2'd0, '0,        1'b1, 5'd31, 32'h3008);
      tbl[2]  = mk(32'h03E02809, 32'h3010, 32'hBEEF,     '0,   2'd0, '0,        1'b1, 5'd5,  32'h3018);
      tbl[3]  = mk(32'h80890000, 32'h3020, '0,           rd_w, 2'd3, '0,        1'b1, 5'd9,  32'hFFFFFF80);
      tbl[4]  = mk(32'h90890000, 32'h3024, '0,           rd_w, 2'd2, '0,        1'b1, 5'd9,  32'h000000FF);
      tbl[5]  = mk(32'h84890000, 32'h3028, '0,           rd_w, 2'd2, '0,        1'b1, 5'd9,  32'hFFFF80FF);
      tbl[6]  = mk(32'h94890000, 32'h302C, '0,           rd_w, 2'd0, '0,        1'b1, 5'd9,  32'h00007F01);
      tbl[7]  = mk(32'h8C890000, 32'h3030, '0,           rd_w, 2'd0, '0,        1'b1, 5'd9,  32'h80FF7F01);
      tbl[8]  = mk(32'h8C890000, 32'h3034, '0,           rd_w, 2'd3, '0,        1'b1, 5'd9,  32'h80FF7F01);
      tbl[9]  = mk(32'h84890000, 32'h3038, '0,           rd_w, 2'd3, '0,        1'b1, 5'd9,  32'hFFFF80FF);
      tbl[10] = mk(32'h80890000, 32'h303C, '0,           rd_w, 2'd1, '0,        1'b1, 5'd9,  32'h0000007F);
      tbl[11] = mk(32'h00220021, 32'h3040, '0,           '0,   2'd0, '0,        1'b0, 5'd0,  32'h0);
      tbl[12] = mk(32'h00000000, 32'h3044, '0,           '0,   2'd0, '0,        1'b0, 5'd0,  32'h0);
      tbl[13] = mk(32'hFC221234, 32'h3048, 32'hDEAD,     rd_w, 2'd0, 32'h1,     1'b0, 5'd0,  32'h0);
      tbl[14] = mk(32'h400A6000, 32'h304C, 32'h1,        '0,   2'd0, 32'hCAFE,  1'b1, 5'd10, 32'hCAFE);
      tbl[15] = mk(32'h408A6000, 32'h3050, 32'h1,        '0,   2'd0, 32'hCAFE,  1'b0, 5'd0,  32'h0);
      tbl[16] = mk(32'h00221823, 32'h3054, 32'h77,       '0,   2'd0, '0,        1'b1, 5'd3,  32'h77);
      tbl[17] = mk(32'h00022100, 32'h3058, 32'h20,       '0,   2'd0, '0,        1'b1, 5'd4,  32'h20);
      tbl[18] = mk(32'h3C07ABCD, 32'h305C, 32'hABCD0000, '0,   2'd0, '0,        1'b1, 5'd7,  32'hABCD0000);
      ori_v = tbl[0];
      mfc_v = tbl[14];
      lw_v  = tbl[7];

      // reset asserted asynchronously, before any clock edge
      #1 reset_n = 1'b0;
      #1;
      chk("rst.valid",   64'(w_valid), 64'd0);
      chk("rst.we",      64'(w_we),    64'd0);
      chk("rst.waddr",   64'(w_waddr), 64'd0);
      chk("rst.wdata",   64'(w_wdata), 64'd0);
      chk("rst.pc",      64'(w_pc),    64'd0);
      chk("rst.instret", 64'(instret), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 19; i++) begin
         drive(tbl[i], 1'b1);
         push_exp(tbl[i]);
         edge_step();
         check_out($sformatf("vec%0d", i));
      end

      // stall: W holds the ori while M keeps changing
      drive(ori_v, 1'b1); push_exp(ori_v); edge_step(); check_out("pre_stall");
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(mfc_v, 1'b1); push_exp(ori_v); edge_step();
         check_out($sformatf("stall%0d", k));
      end
      flush = 1'b1;
      edge_step();
      chk("flush_stall.valid",   64'(w_valid), 64'd0);
      chk("flush_stall.we",      64'(w_we),    64'd0);
      chk("flush_stall.instret", 64'(instret), 64'(mdl_instret));
      stall = 1'b0;
      flush = 1'b0;

      // bubble: real-looking ir but m_valid=0
      drive(ori_v, 1'b0); edge_step();
      chk("bubble.valid", 64'(w_valid), 64'd0);
      chk("bubble.we",    64'(w_we),    64'd0);

      // flush alone still retires the instruction leaving W
      drive(ori_v, 1'b1); push_exp(ori_v); edge_step(); check_out("pre_flush");
      flush = 1'b1; drive(mfc_v, 1'b1); edge_step();
      chk("flush.valid",   64'(w_valid), 64'd0);
      chk("flush.we",      64'(w_we),    64'd0);
      chk("flush.instret", 64'(instret), 64'(mdl_instret));
      flush = 1'b0;

      // counter wrap from 0xFFFFFFFF
      drive(ori_v, 1'b1); push_exp(ori_v); edge_step(); check_out("pre_wrap");
      force dut.instret_cur = 32'hFFFFFFFF;
      mdl_instret = 32'hFFFFFFFF;
      #1 chk("wrap.preload", 64'(instret), 64'hFFFFFFFF);
      drive(lw_v, 1'b1); push_exp(lw_v); edge_step();
      release dut.instret_cur;
      #1 check_out("wrap");

      // asynchronous reset mid-cycle while a write is pending
      drive(ori_v, 1'b1); push_exp(ori_v); edge_step(); check_out("pre_arst");
      #1 reset_n = 1'b0;
      #1;
      chk("arst.we",      64'(w_we),    64'd0);
      chk("arst.valid",   64'(w_valid), 64'd0);
      chk("arst.waddr",   64'(w_waddr), 64'd0);
      chk("arst.instret", 64'(instret), 64'd0);
      mdl_valid = 1'b0;
      mdl_instret = '0;
      @(negedge clk);
      reset_n = 1'b1;
      drive(lw_v, 1'b1); push_exp(lw_v); edge_step(); check_out("post_arst");

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule

// File: doc/wb_stage_unit.md
# wb_stage_unit

Parametrised write-back stage of the pipelined MIPS core. It holds the M/W pipeline register with stall and flush control, and decodes the registered instruction into the GRF write port: enable, destination and data. It performs in-stage byte/half/word load extension from the captured memory word and counts retired instructions. It sits between the M-stage datapath and the GRF write port, and its write outputs also feed the hazard/forwarding unit.

## Interface
- DATA_W, 32, datapath width; multiple of 32 (32 or 64)
- RA_W, 5, register address width
- LINK_REG, 31, destination register for jal
- LINK_OFF, 8, added to PC to form the link value for jal/jalr
- LANE_W, $clog2(DATA_W/8), derived; byte-lane address bits
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- m_valid  in  1  M stage holds a real instruction
- m_ir  in  32  M-stage instruction word
- m_pc  in  32  M-stage PC
- m_alu  in  DATA_W  ALU result
- m_rdata  in  DATA_W  aligned data-memory read word
- m_addr_lo  in  LANE_W  low bits of the load address
- m_cp0  in  DATA_W  CP0 read data, for mfc0
- stall  in  1  hold the W register
- flush  in  1  load a bubble into the W register
- w_valid  out  1  W register holds a real instruction
- w_we  out  1  GRF write enable
- w_waddr  out  RA_W  GRF write address
- w_wdata  out  DATA_W  GRF write data
- w_pc  out  32  W-stage PC, for debug and trace
- instret  out  32  retired-instruction counter

## Operation
- Register update priority: reset, then flush, then stall, then load.
  - flush: valid<=0 and ir<=0; other fields don't care.
  - stall: all fields hold.
  - load: capture m_valid, m_ir, m_pc, m_alu, m_rdata, m_addr_lo and m_cp0.
- Decode operates on the registered instruction. op=ir[31:26], rs=ir[25:21], rt=ir[20:16], rd=ir[15:11], funct=ir[5:0].
- Class RR: op 0x00 with funct in {00,02,03,04,06,07,20,21,22,23,24,25,26,27,2A,2B}. Destination rd, data alu.
- Class JALR: op 0x00, funct 0x09. Destination rd, data pc+LINK_OFF.
- Class RI: op in {08,09,0A,0B,0C,0D,0E,0F}. Destination rt, data alu.
- Class LOAD: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25. Destination rt, data is the extended load value.
- Class MFC0: op 0x10 with rs=0. Destination rt, data cp0.
- Class JAL: op 0x03. Destination LINK_REG, data pc+LINK_OFF. The PC sum is zero-extended to DATA_W.
- Any other encoding gives w_we=0. w_waddr and w_wdata are then 0.
- w_we = valid & class_hit & (w_waddr != 0). A write to $0 is always suppressed, so an all-zero sll nop never writes.
- Load extension (little-endian):
  - Byte lane b = addr_lo selects rdata[8b+7:8b].
  - Halfword uses lane {addr_lo[LANE_W-1:1],0}, 16 bits.
  - Word uses lane {addr_lo[LANE_W-1:2],00}, 32 bits.
  - lb, lh and lw sign-extend to DATA_W; lbu and lhu zero-extend.
  - Misalignment is not checked here; the low ignored bits are dropped.
- instret:
  - Increments by 1 on each edge where w_valid=1 and stall=0.
  - Flush does not block the increment for the instruction currently leaving W.
  - Wraps 0xFFFFFFFF->0.

## Timing
- All outputs reset to 0: w_valid, w_we, w_waddr, w_wdata, w_pc, instret.
- Reset is asynchronous: asserting reset_n=0 mid-stream clears the W register and instret immediately, not at the next edge.
- Latency is 1 cycle: M inputs sampled at edge N appear on the W outputs after edge N.
- Write outputs are combinational from W state, so the GRF writes at edge N+1.
- Under stall, w_we/w_waddr/w_wdata are held, and the GRF rewrite is idempotent.
- flush and stall in the same cycle: flush wins.
- m_valid=0 is loaded as a bubble: w_valid=0 and w_we=0, whatever the ir value.

## Test plan
- Reset then release: all outputs 0. Check again after reset_n=0 mid-run with w_we=1; w_we must drop with no clock edge.
- ori $8,$0,0x1234 with alu=0x1234: next cycle w_we=1, w_waddr=8, w_wdata=0x1234, instret +1.
- jal at pc=0x3000 -> w_waddr=31, w_wdata=0x3008. jalr rd=5 at pc=0x3010 -> w_waddr=5, w_wdata=0x3018.
- Loads with rdata=0x80FF7F01, all to rt=9:
  - lb, addr_lo=3: w_wdata=0xFFFFFF80
  - lbu, addr_lo=2: w_wdata=0x000000FF
  - lh, addr_lo=2: w_wdata=0xFFFF80FF
  - lhu, addr_lo=0: w_wdata=0x00007F01
  - lw: w_wdata=0x80FF7F01
- Write to $0 and nop:
  - addu with rd=0 -> w_we=0.
  - ir=0 -> w_we=0.
  - Unknown opcode 0x3F -> w_we=0, w_waddr=0, w_wdata=0.
- Hold and bubble control:
  - stall for 3 cycles: outputs held and instret unchanged.
  - flush together with stall: next cycle w_valid=0.
  - Preload instret to 0xFFFFFFFF and retire one instruction: instret=0.
